// File: rtl/pulse_bram_readout.sv
// pulse_bram_readout
// Streams one 32-bit BRAM word per sample tick out to a valid/ready consumer,
// optionally clearing each word after it has been handed off so the frame
// buffer is empty for the next accumulation pass.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   enable           readout enable (level); falling edge clears overrun
//   tick             one-cycle request for the next word
//   bram_addr        byte address to BRAM (word index * 4)
//   bram_data_in     BRAM write data (always the clear value 0)
//   bram_we          BRAM write enable (only during the clear cycle)
//   bram_ena         BRAM enable
//   bram_data_out    BRAM read data, one cycle after the address edge
//   m_data, m_valid  output sample and valid, held until m_ready
//   m_ready          consumer accept
//   frame_done       one-cycle pulse when the word index wraps to 0
//   overrun          sticky: a tick arrived while a transaction was busy
module pulse_bram_readout #(
  parameter int unsigned DEPTH         = 2064,
  parameter bit          CLEAR_ON_READ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        tick,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_data_in,
  output logic        bram_we,
  output logic        bram_ena,
  input  logic [31:0] bram_data_out,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        frame_done,
  output logic        overrun
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    OUT  = 3'd3,
    CLR  = 3'd4,
    NXT  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              we_q, we_d;
  logic              ena_q, ena_d;
  logic [31:0]       mdata_q, mdata_d;
  logic              mvalid_q, mvalid_d;
  logic              fdone_q, fdone_d;
  logic              ovr_q, ovr_d;
  logic              en_prev_q;

  logic [31:0]       word_addr;
  logic              enable_fall;

  // Zero-extended word index to byte address; idx never exceeds DEPTH-1.
  assign word_addr   = 32'(idx_q) << 2;
  assign enable_fall = en_prev_q & ~enable;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and registered-output next values
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    din_d    = din_q;
    we_d     = 1'b0;
    ena_d    = ena_q;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q;
    fdone_d  = 1'b0;

    // Enable falling edge clears overrun; a busy-time tick in the same cycle still sets it.
    ovr_d = enable_fall ? 1'b0 : ovr_q;
    if (tick && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        ena_d = 1'b0;
        if (!enable) begin
          // Next enabled frame always restarts from word 0.
          idx_d = '0;
        end else if (tick) begin
          addr_d  = word_addr;
          ena_d   = 1'b1;
          state_d = RD;
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        mdata_d  = bram_data_out;
        mvalid_d = 1'b1;
        ena_d    = 1'b0;
        state_d  = OUT;
      end
      OUT: begin
        if (mvalid_q && m_ready) begin
          mvalid_d = 1'b0;
          if (CLEAR_ON_READ) begin
            addr_d  = word_addr;
            din_d   = '0;
            we_d    = 1'b1;
            ena_d   = 1'b1;
            state_d = CLR;
          end else begin
            state_d = NXT;
          end
        end
      end
      CLR: begin
        ena_d   = 1'b0;
        state_d = NXT;
      end
      NXT: begin
        ena_d = 1'b0;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          fdone_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      we_q      <= 1'b0;
      ena_q     <= 1'b0;
      mdata_q   <= '0;
      mvalid_q  <= 1'b0;
      fdone_q   <= 1'b0;
      ovr_q     <= 1'b0;
      en_prev_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      we_q      <= we_d;
      ena_q     <= ena_d;
      mdata_q   <= mdata_d;
      mvalid_q  <= mvalid_d;
      fdone_q   <= fdone_d;
      ovr_q     <= ovr_d;
      en_prev_q <= enable;
    end
  end

  assign bram_addr    = addr_q;
  assign bram_data_in = din_q;
  assign bram_we      = we_q;
  assign bram_ena     = ena_q;
  assign m_data       = mdata_q;
  assign m_valid      = mvalid_q;
  assign frame_done   = fdone_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_pulse_bram_readout.sv
// Bench for pulse_bram_readout: three instances (default, DEPTH=4,
// DEPTH=8 without clear-on-read), each with a synchronous BRAM model, driven
// by directed transactions with random data and stall lengths and compared
// against a word-level reference model (array contents + frame index).
module tb_pulse_bram_readout;

  localparam int unsigned MAXD = 2064;

  logic clk;
  logic rst_n;
  logic [2:0] enable, tick, m_ready;
  logic [2:0] we, ena, m_valid, frame_done, overrun;
  logic [2:0][31:0] addr, din, dout, m_data;

  logic [31:0] bram [3][MAXD];
  logic [31:0] mmem [3][MAXD];
  logic        load_en;
  int unsigned we_cnt [3]  = '{0, 0, 0};
  int unsigned oob_cnt [3] = '{0, 0, 0};

  int unsigned midx [3];
  int unsigned mclr [3];
  int checks   = 0;
  int failures = 0;

  function automatic int unsigned depth_of(input int i);
    case (i)
      0:       return 2064;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  pulse_bram_readout u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable[0]), .tick(tick[0]),
    .bram_addr(addr[0]), .bram_data_in(din[0]), .bram_we(we[0]), .bram_ena(ena[0]),
    .bram_data_out(dout[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready[0]), .frame_done(frame_done[0]), .overrun(overrun[0])
  );

  pulse_bram_readout #(.DEPTH(4), .CLEAR_ON_READ(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable[1]), .tick(tick[1]),
    .bram_addr(addr[1]), .bram_data_in(din[1]), .bram_we(we[1]), .bram_ena(ena[1]),
    .bram_data_out(dout[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready[1]), .frame_done(frame_done[1]), .overrun(overrun[1])
  );

  pulse_bram_readout #(.DEPTH(8), .CLEAR_ON_READ(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable[2]), .tick(tick[2]),
    .bram_addr(addr[2]), .bram_data_in(din[2]), .bram_we(we[2]), .bram_ena(ena[2]),
    .bram_data_out(dout[2]), .m_data(m_data[2]), .m_valid(m_valid[2]),
    .m_ready(m_ready[2]), .frame_done(frame_done[2]), .overrun(overrun[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous read-first BRAM models with write and out-of-range counters
  always @(posedge clk) begin
    int unsigned w;
    if (load_en) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < int'(MAXD); j++) bram[i][j] <= mmem[i][j];
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (we[i]) we_cnt[i] <= we_cnt[i] + 1;
      if (ena[i]) begin
        w = addr[i] >> 2;
        if (addr[i] >= 32'(depth_of(i) * 4)) begin
          oob_cnt[i] <= oob_cnt[i] + 1;
        end else begin
          if (we[i]) bram[i][w] <= din[i];
          dout[i] <= bram[i][w];
        end
      end
    end
  end

  task automatic check32(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d]: observed=%08h expected=%08h", tag, i, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input int i, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d]: observed=%b expected=%b", tag, i, obs, exp);
    end
  endtask

  task automatic check_reset(input int i);
    check32("rst_addr", i, addr[i], 32'd0);
    check32("rst_din", i, din[i], 32'd0);
    check1("rst_we", i, we[i], 1'b0);
    check1("rst_ena", i, ena[i], 1'b0);
    check32("rst_mdata", i, m_data[i], 32'd0);
    check1("rst_mvalid", i, m_valid[i], 1'b0);
    check1("rst_fdone", i, frame_done[i], 1'b0);
    check1("rst_ovr", i, overrun[i], 1'b0);
  endtask

  // One full tick->read->handshake->(clear)->advance transaction, checked cycle by cycle.
  task automatic transact(input int i, input int stall, input bit tick_in_stall, input bit drop_en);
    logic [31:0] ea, ed;
    bit          wrap, clr;
    clr  = (i != 2);
    ea   = 32'(midx[i]) << 2;
    ed   = mmem[i][midx[i]];
    wrap = (midx[i] == depth_of(i) - 1);
    m_ready[i] = (stall == 0);
    tick[i] = 1'b1;
    @(negedge clk);
    tick[i] = 1'b0;
    check32("rd_addr", i, addr[i], ea);
    check1("rd_ena", i, ena[i], 1'b1);
    check1("rd_we", i, we[i], 1'b0);
    check1("valid_early", i, m_valid[i], 1'b0);
    @(negedge clk);
    check1("valid_not_yet", i, m_valid[i], 1'b0);
    @(negedge clk);
    check1("valid_rise", i, m_valid[i], 1'b1);
    check32("data", i, m_data[i], ed);
    check1("cap_ena", i, ena[i], 1'b0);
    for (int s = 0; s < stall; s++) begin
      if (s == 0 && drop_en) enable[i] = 1'b0;
      if (s == 1 && tick_in_stall) tick[i] = 1'b1;
      @(negedge clk);
      tick[i] = 1'b0;
      check1("stall_valid", i, m_valid[i], 1'b1);
      check32("stall_data", i, m_data[i], ed);
      check1("stall_we", i, we[i], 1'b0);
    end
    if (tick_in_stall) check1("ovr_set", i, overrun[i], 1'b1);
    m_ready[i] = 1'b1;
    @(negedge clk);
    check1("valid_drop", i, m_valid[i], 1'b0);
    if (clr) begin
      check1("clr_we", i, we[i], 1'b1);
      check1("clr_ena", i, ena[i], 1'b1);
      check32("clr_addr", i, addr[i], ea);
      check32("clr_din", i, din[i], 32'd0);
      mmem[i][midx[i]] = 32'd0;
      mclr[i]++;
      @(negedge clk);
      check1("nxt_we", i, we[i], 1'b0);
    end else begin
      check1("noclr_we", i, we[i], 1'b0);
    end
    @(negedge clk);
    check1("frame_done", i, frame_done[i], wrap);
    midx[i] = wrap ? 0 : midx[i] + 1;
    @(negedge clk);
    check1("frame_done_once", i, frame_done[i], 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = '0;
    tick    = '0;
    m_ready = '1;
    load_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      midx[i] = 0;
      mclr[i] = 0;
      for (int j = 0; j < int'(MAXD); j++) mmem[i][j] = $urandom;
    end
    mmem[0][0] = 32'h3E99652C;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 3'b111;
    @(negedge clk);

    // Known word 0, immediate accept, then clear
    transact(0, 0, 1'b0, 1'b0);
    repeat (6) transact(0, int'($urandom_range(0, 4)), 1'b0, 1'b0);
    check1("ovr_none", 0, overrun[0], 1'b0);

    // Long stall with a dropped tick
    transact(0, 10, 1'b1, 1'b0);
    transact(0, 1, 1'b0, 1'b0);
    check1("ovr_sticky", 0, overrun[0], 1'b1);

    // Enable dropped during OUT: completes, then no reads, restart at 0
    transact(0, 3, 1'b0, 1'b1);
    midx[0] = 0;
    check1("ovr_clr_disable", 0, overrun[0], 1'b0);
    repeat (3) begin
      tick[0] = 1'b1;
      @(negedge clk);
      tick[0] = 1'b0;
      check1("dis_ena", 0, ena[0], 1'b0);
      @(negedge clk);
      check1("dis_ena2", 0, ena[0], 1'b0);
    end
    enable[0] = 1'b1;
    @(negedge clk);
    transact(0, 0, 1'b0, 1'b0);
    check1("ovr_after_reenable", 0, overrun[0], 1'b0);

    // DEPTH=4: wrap on 4th, 5th re-reads word 0 (now cleared)
    for (int k = 0; k < 5; k++) begin
      transact(1, int'($urandom_range(0, 3)), 1'b0, 1'b0);
      repeat (2) @(negedge clk);
    end

    // No clear-on-read: second frame returns the same values
    for (int k = 0; k < 10; k++) transact(2, int'($urandom_range(0, 3)), 1'b0, 1'b0);

    // Reset asserted during the clear cycle
    m_ready[0] = 1'b1;
    tick[0] = 1'b1;
    @(negedge clk);
    tick[0] = 1'b0;
    check32("pre_rst_addr", 0, addr[0], 32'(midx[0]) << 2);
    repeat (3) @(negedge clk);
    check1("pre_rst_we", 0, we[0], 1'b1);
    #1 rst_n = 1'b0;
    #1 check_reset(0);
    for (int i = 0; i < 3; i++) midx[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    transact(0, 0, 1'b0, 1'b0);
    transact(0, 2, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check32("we_count", i, we_cnt[i], mclr[i]);
      check32("oob_count", i, oob_cnt[i], 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_bram_readout.md
PULSE_BRAM_READOUT -- requirements
Module: pulse_bram_readout

Interface
REQ-001 Parameter DEPTH, default 2064: number of 32-bit BRAM words in one frame (covers LFSR max 2047 plus 13-word pulse plus margin).
REQ-002 Parameter CLEAR_ON_READ, default 1: when 1, each word is written to 0 after it is consumed.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  readout enable; level.
REQ-006 tick  input  1  sample-rate strobe, one-cycle pulse requesting one word.
REQ-007 bram_addr  output  32  byte address to BRAM, word index * 4.
REQ-008 bram_data_in  output  32  write data to BRAM (clear value).
REQ-009 bram_we  output  1  BRAM write enable.
REQ-010 bram_ena  output  1  BRAM enable.
REQ-011 bram_data_out  input  32  BRAM read data, valid one clock after the address edge.
REQ-012 m_data  output  32  fp32 accumulated pulse sample.
REQ-013 m_valid  output  1  m_data valid; held until accepted.
REQ-014 m_ready  input  1  consumer accept.
REQ-015 frame_done  output  1  one-cycle pulse when the index wraps DEPTH-1 -> 0.
REQ-016 overrun  output  1  sticky flag: a tick arrived while a transaction was in progress.

Function
REQ-017 The block SHALL own a word index idx (range 0..DEPTH-1) and a state machine with states IDLE, RD, CAP, OUT, CLR, NXT.
REQ-018 IDLE: when enable=1 and tick=1, register bram_addr=idx*4, bram_ena=1, bram_we=0, go to RD; otherwise bram_ena=0, bram_we=0.
REQ-019 RD: hold address and ena; go to CAP unconditionally (BRAM read latency 1 cycle).
REQ-020 CAP: latch m_data=bram_data_out, set m_valid=1, drop bram_ena, go to OUT; m_valid SHALL rise on the 2nd edge after the tick edge.
REQ-021 OUT: hold m_data and m_valid stable while m_ready=0; on edge with m_valid=1 and m_ready=1 clear m_valid and go to CLR if CLEAR_ON_READ=1, else NXT.
REQ-022 CLR: drive bram_addr=idx*4, bram_data_in=0, bram_we=1, bram_ena=1 for exactly one cycle, then NXT.
REQ-023 NXT: bram_we=0, bram_ena=0; idx=idx+1, or 0 if idx=DEPTH-1 with frame_done=1 on that same edge; return to IDLE.
REQ-024 frame_done SHALL be high for exactly one cycle per wrap and 0 otherwise.
REQ-025 A tick in any state other than IDLE SHALL be dropped and SHALL set overrun=1; overrun clears only on reset or on enable 1->0 transition.
REQ-026 tick and m_ready simultaneous in OUT: handshake completes, tick counts as overrun.
REQ-027 enable deasserted mid-transaction: current transaction SHALL complete through NXT; no new transaction starts while enable=0.
REQ-028 enable=0 while in IDLE SHALL reset idx to 0 so that the next enabled frame starts at address 0.
REQ-029 Address arithmetic SHALL be zero-extended idx shifted left by 2 into 32 bits; no address >= DEPTH*4 is ever driven.
REQ-030 bram_we SHALL never be high in any state other than CLR; m_data is not modified while m_valid=1.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, idx=0, bram_addr=0, bram_data_in=0, bram_we=0, bram_ena=0, m_data=0, m_valid=0, frame_done=0, overrun=0.
REQ-032 Reset asserted mid-transaction (including CLR) SHALL abort it with bram_we low immediately; no partial write is completed after rst_n rises.
REQ-033 After rst_n rises, the first tick with enable=1 SHALL read address 0.

Verification
REQ-034 Preload word 0 = 32'h3E99652C, enable=1, m_ready=1, one tick -> bram_addr=0, m_valid high 2 edges later with m_data=32'h3E99652C, then one CLR cycle writing 0 to address 0.
REQ-035 m_ready=0 for 10 cycles after m_valid -> m_data/m_valid stable, no CLR write until m_ready=1; second tick during stall -> overrun=1.
REQ-036 DEPTH=4, 4 ticks spaced 8 cycles -> addresses 0,4,8,12 read, frame_done single pulse on 4th NXT, 5th tick reads address 0 again.
REQ-037 CLEAR_ON_READ=0, same word read on two frames -> both return the preloaded value, bram_we never high.
REQ-038 rst_n low during CLR -> bram_we=0 same cycle, all outputs at reset values, next tick reads address 0.
REQ-039 enable dropped while in OUT -> handshake and CLR complete, then no reads on further ticks; re-enable -> read from address 0, overrun cleared.
